// File: rtl/serdes_pkg.sv
// Shared encodings for the byte serializer and the UART TX path.
// State codes are exported as plain localparams so other blocks can decode them.
package serdes_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] SEND = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_POP  = POP,
        S_LOAD = LOAD,
        S_SEND = SEND
    } state_t;

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops whole words from the FIFO read port and streams them out as bytes on valid/ready.
// One word is in flight at a time; the next pop only happens after its last byte is accepted.
module fifo_word_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             fifo_empty,
    output logic             fifo_rden,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int NB    = WIDTH / BYTE_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   sr_shift;
    logic [IDX_W-1:0]   idx;
    logic               accept;
    logic               last_byte;

    // Byte presented on tx_data for a given register image.
    function automatic logic [7:0] head_byte(input logic [WIDTH-1:0] w);
        if (LSB_FIRST != 0) return w[BYTE_W-1:0];
        else                return w[WIDTH-1 -: BYTE_W];
    endfunction

    assign accept    = tx_valid & tx_ready;
    assign last_byte = (idx == IDX_W'(NB - 1));
    assign sr_shift  = (LSB_FIRST != 0) ? (sr >> BYTE_W) : (sr << BYTE_W);

    always_ff @(posedge iclk) begin
        if (irst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_rden = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (!fifo_empty) state_nxt = S_POP;
            end
            S_POP: begin
                fifo_rden = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = S_SEND;
            S_SEND: begin
                if (accept && last_byte)
                    state_nxt = fifo_empty ? S_IDLE : S_POP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // tx_valid is registered and tracks state==SEND exactly, so it never retracts mid-byte.
    always_ff @(posedge iclk) begin
        if (irst) begin
            sr         <= '0;
            idx        <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            words_sent <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    sr       <= fifo_dout;
                    idx      <= '0;
                    tx_data  <= head_byte(fifo_dout);
                    tx_valid <= 1'b1;
                end
                S_SEND: begin
                    if (accept) begin
                        sr      <= sr_shift;
                        tx_data <= head_byte(sr_shift);
                        if (last_byte) begin
                            idx        <= '0;
                            tx_valid   <= 1'b0;
                            words_sent <= words_sent + CNT_W'(1);
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: tx_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench: FIFO model feeding an LSB-first serializer (narrow counter to reach wrap) and an
// MSB-first instance; byte order, stalls and word counts are checked against a queue model.
module tb_fifo_word_serializer;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    always #5 iclk = ~iclk;

    // LSB-first instance, 4-bit counter so wrap is reachable
    logic        empty0, rden0, txv0, busy0;
    logic        txr0 = 1'b0;
    logic [63:0] dout0 = '0;
    logic [7:0]  txd0;
    logic [3:0]  ws0;

    // MSB-first instance
    logic        empty1, rden1, txv1, busy1;
    logic        txr1 = 1'b1;
    logic [63:0] dout1 = '0;
    logic [7:0]  txd1;
    logic [15:0] ws1;

    fifo_word_serializer #(.WIDTH(64), .LSB_FIRST(1), .CNT_W(4)) dut0 (
        .iclk(iclk), .irst(irst), .fifo_empty(empty0), .fifo_rden(rden0),
        .fifo_dout(dout0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
        .busy(busy0), .words_sent(ws0)
    );

    fifo_word_serializer #(.WIDTH(64), .LSB_FIRST(0), .CNT_W(16)) dut1 (
        .iclk(iclk), .irst(irst), .fifo_empty(empty1), .fifo_rden(rden1),
        .fifo_dout(dout1), .tx_data(txd1), .tx_valid(txv1), .tx_ready(txr1),
        .busy(busy1), .words_sent(ws1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO model for dut0: registered dout, one-cycle read latency
    logic [63:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit flush  = 1'b0;
    assign empty0 = (wr_ptr == rd_ptr);

    always @(posedge iclk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (rden0) begin
            dout0  <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Single-entry source for dut1
    logic [63:0] word1 = '0;
    bit have1 = 1'b0;
    assign empty1 = !have1;
    always @(posedge iclk) if (rden1) begin
        dout1 <= word1;
        have1 <= 1'b0;
    end

    // Reference model: expected byte stream and word count
    logic [7:0] exp_q [$];
    logic [7:0] q1 [$];
    int  pos        = 0;
    int  exp_cnt    = 0;
    int  rcnt       = 0;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic push(input logic [63:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
        for (int k = 0; k < 8; k++) exp_q.push_back(w[8*k +: 8]);
    endtask

    task automatic model_reset();
        exp_q.delete();
        pos        = 0;
        exp_cnt    = 0;
        prev_stall = 1'b0;
    endtask

    always @(negedge iclk) begin
        if (irst) begin
            model_reset();
        end else begin
            chk("words_sent", 64'(ws0), 64'(exp_cnt % 16));
            if (prev_stall) begin
                chk("stall_valid", 64'(txv0), 64'd1);
                chk("stall_data", 64'(txd0), 64'(prev_data));
            end
            if (rden0) begin
                rcnt++;
                chk("rden_nonempty", 64'(empty0), 64'd0);
                chk("rden_idle_tx", 64'(txv0), 64'd0);
            end
            if (txv0 && txr0) begin
                chk("extra_byte", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) chk("byte", 64'(txd0), 64'(exp_q.pop_front()));
                pos++;
                if (pos == 8) begin
                    pos = 0;
                    exp_cnt++;
                end
            end
            prev_stall = txv0 && !txr0;
            prev_data  = txd0;
            if (txv1 && txr1) q1.push_back(txd1);
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && !busy0) break;
            tick();
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] w;
        int acc;
        int pushed;

        // Reset with a word already visible in both sources
        #1;
        push(64'hdead_beef_0bad_f00d);
        word1 = 64'h1;
        have1 = 1'b1;
        tick();
        tick();
        @(negedge iclk);
        chk("rst_rden", 64'(rden0), 64'd0);
        chk("rst_valid", 64'(txv0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_words", 64'(ws0), 64'd0);
        chk("rst_rden1", 64'(rden1), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        flush = 1'b1;
        have1 = 1'b0;
        tick();
        flush = 1'b0;
        model_reset();
        irst = 1'b0;
        tick();

        // Single word, latency and consecutive bytes
        txr0 = 1'b1;
        push(64'h0807060504030201);
        @(negedge iclk);
        chk("lat_c0_rden", 64'(rden0), 64'd0);
        @(negedge iclk);
        chk("lat_c1_rden", 64'(rden0), 64'd1);
        @(negedge iclk);
        chk("lat_c2_valid", 64'(txv0), 64'd0);
        @(negedge iclk);
        for (int i = 0; i < 8; i++) begin
            chk("single_valid", 64'(txv0), 64'd1);
            chk("single_byte", 64'(txd0), 64'(i + 1));
            @(negedge iclk);
        end
        chk("single_idle", 64'(busy0), 64'd0);
        chk("single_count", 64'(ws0), 64'd1);
        #1;

        // Backpressure with ready pattern 1,0,0
        push({$urandom, $urandom});
        push({$urandom, $urandom});
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && !busy0) break;
            txr0 = (c % 3 == 0);
            tick();
        end
        chk("bp_drain", 64'(exp_q.size()), 64'd0);
        chk("bp_count", 64'(ws0), 64'd3);

        // Back-to-back: three words, 24 bytes in 30 cycles
        txr0 = 1'b1;
        rcnt = 0;
        push({$urandom, $urandom});
        push({$urandom, $urandom});
        push({$urandom, $urandom});
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge iclk);
            if (txv0) break;
        end
        chk("b2b_start", 64'(txv0), 64'd1);
        for (int c = 0; c < 30; c++) begin
            if (txv0 && txr0) acc++;
            @(negedge iclk);
        end
        chk("b2b_bytes", 64'(acc), 64'd24);
        chk("b2b_pops", 64'(rcnt), 64'd3);
        chk("b2b_count", 64'(ws0), 64'd6);
        chk("b2b_idle", 64'(busy0), 64'd0);
        #1;

        // MSB-first ordering
        word1 = 64'h1122334455667788;
        have1 = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (q1.size() >= 8 && !busy1) break;
            tick();
        end
        chk("msb_nbytes", 64'(q1.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            w = (q1.size() > 0) ? 64'(q1.pop_front()) : 64'hffff;
            chk("msb_byte", w, 64'(8'(8'h11 * (k + 1))));
        end
        chk("msb_count", 64'(ws1), 64'd1);

        // Mid-word reset after three accepted bytes
        irst = 1'b1;
        tick();
        irst = 1'b0;
        model_reset();
        tick();
        push({$urandom, $urandom});
        for (int c = 0; c < 50; c++) begin
            @(negedge iclk);
            #1;
            if (pos == 3) break;
        end
        chk("mid_reached", 64'(pos), 64'd3);
        irst = 1'b1;
        @(posedge iclk);
        #1;
        irst = 1'b0;
        model_reset();
        @(negedge iclk);
        chk("mid_busy", 64'(busy0), 64'd0);
        chk("mid_valid", 64'(txv0), 64'd0);
        chk("mid_count", 64'(ws0), 64'd0);
        #1;
        push(64'h0f0e0d0c0b0a0900);
        drain(100);
        chk("mid_next_count", 64'(ws0), 64'd1);

        // Random traffic: 20 words, random ready, counter wraps
        pushed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (pushed == 20 && exp_q.size() == 0 && !busy0) break;
            txr0 = ($urandom_range(0, 3) != 0);
            if (pushed < 20 && (wr_ptr - rd_ptr) < 3 && $urandom_range(0, 3) == 0) begin
                push({$urandom, $urandom});
                pushed++;
            end
            tick();
        end
        txr0 = 1'b1;
        drain(100);
        chk("rand_count_wrap", 64'(ws0), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
